// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART sender between the CPU TX path (ch0)
// and the RX echo/debug path (ch1), with per-channel sent counters and a launch timeout.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 8,
  parameter int CNT_W         = 8
) (
  input  logic             clk16,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_data,
  output logic             req1_ready,
  input  logic             tx_status,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] sent_cnt0,
  output logic [CNT_W-1:0] sent_cnt1,
  output logic             err_timeout,
  input  logic             clr_err
);
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic             err_q, err_d;
  logic             err_set, win1, rdy0, rdy1;

  // last_q resets to 1 so channel 0 wins the first contended round.
  always_ff @(posedge clk16 or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      tmo_q     <= '0;
      tx_data_q <= '0;
      grant_q   <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    cnt0_d    = cnt0_q;
    cnt1_d    = cnt1_q;
    err_set   = 1'b0;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    win1      = req1_valid && (!req0_valid || !last_q);
    case (state_q)
      IDLE: begin
        if (tx_status) begin
          rdy0 = req0_valid && !win1;
          rdy1 = win1;
        end
        if (rdy0 || rdy1) begin
          tx_data_d = rdy1 ? req1_data : req0_data;
          grant_d   = rdy1 ? 2'b10 : 2'b01;
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_status) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
          // Sender never started: drop the byte but still rotate priority.
          err_set = 1'b1;
          grant_d = '0;
          last_d  = grant_q[1];
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_status) begin
          if (grant_q[1]) cnt1_d = cnt1_q + 1'b1;
          else            cnt0_d = cnt0_q + 1'b1;
          last_d  = grant_q[1];
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q;
    if (clr_err) err_d = 1'b0;
    if (err_set) err_d = 1'b1;
  end

  assign req0_ready  = rdy0;
  assign req1_ready  = rdy1;
  assign tx_data     = tx_data_q;
  assign tx_en       = (state_q == LAUNCH);
  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign sent_cnt0   = cnt0_q;
  assign sent_cnt1   = cnt1_q;
  assign err_timeout = err_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART sender between two byte requesters: channel 0 is the CPU transmit path and channel 1 is the RX echo/debug path. Runs in the clk16 domain. Arbitrates round-robin, issues a one-cycle launch pulse to the sender, and tracks the sender's busy/idle status until the frame completes. Also keeps per-channel sent-byte counters and a sticky launch-timeout error.

Parameters:
START_TIMEOUT, 8, max clk16 cycles to wait in WAIT_BUSY for tx_status to fall after a launch.
CNT_W, 8, width of each sent-byte counter.

Ports:
clk16  input  1  UART oversampling clock.
reset  input  1  asynchronous, active-low reset.
req0_valid  input  1  channel 0 has a byte.
req0_data  input  8  channel 0 byte.
req0_ready  output  1  channel 0 byte accepted this cycle when valid is also high.
req1_valid  input  1  channel 1 has a byte.
req1_data  input  8  channel 1 byte.
req1_ready  output  1  channel 1 byte accepted this cycle when valid is also high.
tx_status  input  1  sender idle (1) / sending (0).
tx_data  output  8  byte to sender, registered.
tx_en  output  1  one-cycle launch pulse to sender.
grant  output  2  one-hot owner of the current transfer; 0 when idle.
busy  output  1  high in any state except IDLE.
sent_cnt0  output  CNT_W  bytes completed on channel 0.
sent_cnt1  output  CNT_W  bytes completed on channel 1.
err_timeout  output  1  sticky launch-timeout flag.
clr_err  input  1  synchronous clear of err_timeout.

Behaviour:
- Reset is asynchronous and active-low; clock is clk16. While reset is low:
  - state=IDLE, tx_en=0, tx_data=0, grant=0, busy=0.
  - sent_cnt0=sent_cnt1=0, err_timeout=0.
  - last-grant pointer=1, so channel 0 wins first; timeout counter=0.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Ready is combinational.
  - reqN_ready=1 only if tx_status=1, N is the arbitration winner, and reqN_valid=1.
  - Winner is the only valid channel; if both are valid, the winner is the channel not equal to last-grant.
  - No ready is asserted while tx_status=0.
  - On accept (valid&ready) at edge T: tx_data<=reqN_data, grant<=one-hot N, go to LAUNCH.
- LAUNCH:
  - tx_en=1 for exactly this one cycle (registered, visible cycle T+1).
  - Go to WAIT_BUSY and clear the timeout counter.
- WAIT_BUSY:
  - tx_status=0 -> WAIT_DONE.
  - Otherwise increment the timeout counter.
  - When the counter reaches START_TIMEOUT with tx_status still 1: set err_timeout, grant<=0, go to IDLE. The byte is dropped, the counter is not incremented, and last-grant<=N (fairness preserved).
- WAIT_DONE:
  - Hold until tx_status=1, then: sent_cntN<=sent_cntN+1 (wraps modulo 2^CNT_W), last-grant<=N, grant<=0, go to IDLE.
  - A new accept is possible on the next cycle.
- No timeout applies in WAIT_DONE; frame length is owned by the sender.
- tx_data holds its value until the next accept. tx_en is never high outside LAUNCH.
- Requesters must hold valid/data stable until ready. Deasserting valid before ready loses nothing, since no data is taken.
- clr_err and a timeout set in the same cycle: set wins, err_timeout=1.
- Both channels valid on consecutive frames: grants strictly alternate 0,1,0,1.
- Reset asserted mid-transfer: immediate return to reset values. tx_en drops asynchronously and the in-flight byte is not counted.
- Throughput: one byte per (3 + sender frame length) cycles minimum.

Test Plan:
- Single byte: reset release, tx_status=1, req0_valid=1 data=8'hA5 -> req0_ready=1 for 1 cycle; next cycle tx_en=1, tx_data=8'hA5, grant=2'b01. Drive tx_status=0 for 160 cycles then 1 -> sent_cnt0=1, busy=0.
- Contention: both valid from reset with data 8'h11 and 8'h22, sender model busy 160 cycles per frame -> launch order 11,22,11,22 with grants alternating; after 4 frames sent_cnt0=2, sent_cnt1=2.
- Not ready: tx_status=0 held in IDLE with req1_valid=1 -> req1_ready stays 0 and tx_en stays 0 for 50 cycles; raise tx_status -> accept within 1 cycle.
- Timeout: sender model ignores tx_en (tx_status stuck 1) -> err_timeout=1 exactly START_TIMEOUT cycles after WAIT_BUSY entry, sent_cnt unchanged, busy=0. Pulse clr_err -> err_timeout=0. clr_err coincident with a second timeout -> err_timeout=1.
- Wrap: CNT_W=2, five channel-0 frames -> sent_cnt0 reads 1.
- Reset mid-frame: assert reset during WAIT_DONE -> all outputs at reset values immediately. After release, next accept goes to channel 0 even if both channels are valid.
